axi_responder: RTL and testbench
================================

AXI_RESPONDER -- requirements
Module: axi_responder

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 40, address width; ID_W, default 16, transaction ID width; DATA_W, default 128, data width; DEPTH, default 256, memory words (power of 2).
REQ-002 s_axi_aclk  in  1  single clock; all logic on rising edge.
REQ-003 s_axi_areset  in  1  reset; synchronous, active-high.
REQ-004 s_axi_awaddr  in  ADDR_W  write burst byte address.
REQ-005 s_axi_awid  in  ID_W  write ID.
REQ-006 s_axi_awlen  in  8  write beats minus 1.
REQ-007 s_axi_awvalid / s_axi_awready  in / out  1 each  AW handshake.
REQ-008 s_axi_wdata  in  DATA_W  write data.
REQ-009 s_axi_wstrb  in  DATA_W/8  byte enables.
REQ-010 s_axi_wlast  in  1  last write beat.
REQ-011 s_axi_wvalid / s_axi_wready  in / out  1 each  W handshake.
REQ-012 s_axi_bresp  out  2  write response.
REQ-013 s_axi_bid  out  ID_W  write response ID.
REQ-014 s_axi_bvalid / s_axi_bready  out / in  1 each  B handshake.
REQ-015 s_axi_araddr  in  ADDR_W  read burst byte address.
REQ-016 s_axi_arid  in  ID_W  read ID.
REQ-017 s_axi_arlen  in  8  read beats minus 1.
REQ-018 s_axi_arvalid / s_axi_arready  in / out  1 each  AR handshake.
REQ-019 s_axi_rdata  out  DATA_W  read data.
REQ-020 s_axi_rresp  out  2  read response.
REQ-021 s_axi_rid  out  ID_W  read ID.
REQ-022 s_axi_rlast  out  1  last read beat.
REQ-023 s_axi_rvalid / s_axi_rready  out / in  1 each  R handshake.

Function
REQ-024 Block SHALL be an AXI4 slave endpoint terminating INCR bursts of full DATA_W beats into a DEPTH x DATA_W memory; size/burst/lock/cache/prot/qos/user are not ported and are treated as INCR, full width.
REQ-025 Word index SHALL be addr[log2(DATA_W/8)+log2(DEPTH)-1 : log2(DATA_W/8)]; byte-offset bits are ignored; index increments by 1 per beat and wraps DEPTH-1 -> 0 within a burst.
REQ-026 A burst SHALL be out-of-range when any awaddr/araddr bit above the index field is 1: writes are discarded with bresp=SLVERR (2'b10); reads return rdata=0 with rresp=SLVERR on every beat; otherwise responses are OKAY (2'b00).
REQ-027 Write FSM SHALL be W_IDLE (awready=1) -> on AW handshake latch addr/id/len -> W_DATA (wready=1; each W handshake writes bytes where wstrb=1, beat count+1) -> W_RESP (bvalid=1, bid=latched id) -> on bready -> W_IDLE.
REQ-028 W_DATA SHALL exit after the beat carrying wlast or the beat with count==awlen, whichever first; if wlast and count==awlen disagree, bresp SHALL be SLVERR (data beats already written remain written).
REQ-029 Read FSM SHALL be R_IDLE (arready=1) -> on AR handshake latch addr/id/len -> R_FETCH (one-cycle memory read) -> R_DATA (rvalid=1, rlast=1 iff count==arlen) -> on R handshake: R_FETCH if beats remain, else R_IDLE; first rvalid 2 cycles after AR handshake; throughput one beat per 2 cycles.
REQ-030 All R outputs SHALL be registered and held stable while rvalid=1 and rready=0; bresp/bid held while bvalid=1 and bready=0.
REQ-031 Read and write FSMs SHALL run independently, one outstanding burst each; awready/arready SHALL be 0 outside their IDLE state.
REQ-032 Read and write of the same word in the same cycle SHALL return the old data (read-before-write).

Reset
REQ-033 On s_axi_areset=1 both FSMs SHALL go to IDLE, awready=arready=1 from the first cycle after reset release and 0 during reset, wready=bvalid=rvalid=rlast=0, bresp=rresp=0, bid=rid=0, rdata=0; in-flight bursts are dropped; memory contents are not cleared.

Structure
REQ-034 Package axi_responder_pkg SHALL hold the write/read state enums and RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
REQ-035 Memory SHALL be sub-module axi_responder_ram: simple dual-port, registered read, per-byte write enable.

Verification
REQ-036 AW addr=0x100,len=3,id=0x5; 4 beats data 0xA0..0xA3, wstrb all-1, wlast on beat 3 -> bresp=OKAY,bid=0x5; AR same addr/len -> rdata 0xA0..0xA3, rlast on beat 3, rid matches.
REQ-037 Write 0xFF..FF at index 255, len=1 -> second beat lands at index 0; readback of index 255 and 0 confirms wrap.
REQ-038 awaddr bit 39 set -> bresp=SLVERR, memory unchanged; araddr bit 20 set, len=1 -> two beats rdata=0, rresp=SLVERR.
REQ-039 wlast asserted on beat 1 of len=3 burst -> burst ends, bresp=SLVERR; rready held 0 for 5 cycles mid-read -> rdata/rlast stable.
REQ-040 Assert s_axi_areset mid-read-burst -> rvalid=0 next cycle, arready=1 after release, prior memory contents intact on readback.

Source files
------------

// File: rtl/axi_responder_pkg.sv
// Shared types and constants for the AXI responder slice.
package axi_responder_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } rstate_e;

endpackage : axi_responder_pkg

// File: rtl/axi_responder_if.sv
// AXI4 subset bus (INCR, full-width beats) between a master and the responder.
interface axi_responder_if #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned DATA_W = 128
);
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [ID_W-1:0]     s_axi_awid;
  logic [7:0]          s_axi_awlen;
  logic                s_axi_awvalid;
  logic                s_axi_awready;
  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wlast;
  logic                s_axi_wvalid;
  logic                s_axi_wready;
  logic [1:0]          s_axi_bresp;
  logic [ID_W-1:0]     s_axi_bid;
  logic                s_axi_bvalid;
  logic                s_axi_bready;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [ID_W-1:0]     s_axi_arid;
  logic [7:0]          s_axi_arlen;
  logic                s_axi_arvalid;
  logic                s_axi_arready;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic [ID_W-1:0]     s_axi_rid;
  logic                s_axi_rlast;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bresp, s_axi_bid, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bresp, s_axi_bid, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rresp, s_axi_rid, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

endinterface : axi_responder_if

// File: rtl/axi_responder_ram.sv
// Simple dual-port word memory: byte-enabled write port, registered read port.
module axi_responder_ram #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned IDX_W  = $clog2(DEPTH),
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [STRB_W-1:0] wr_be,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  import axi_responder_pkg::*;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Registered read; old data on a same-cycle collision, zero for error bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_clr ? '0 : mem[rd_idx];
    end
  end

endmodule : axi_responder_ram

// File: rtl/axi_responder.sv
// AXI4 slave endpoint terminating INCR bursts into a local word memory.
module axi_responder #(
  parameter int unsigned ADDR_W = 40,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 256
) (
  input  logic            s_axi_aclk,
  input  logic            s_axi_areset,
  axi_responder_if.slave  s_axi
);
  import axi_responder_pkg::*;

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned HI_LSB = OFF_W + IDX_W;

  wstate_e            wstate;
  logic [IDX_W-1:0]   w_idx;
  logic [ID_W-1:0]    w_id;
  logic [7:0]         w_len;
  logic [7:0]         w_cnt;
  logic               w_err;

  rstate_e            rstate;
  logic [IDX_W-1:0]   r_idx;
  logic [ID_W-1:0]    r_id;
  logic [7:0]         r_len;
  logic [7:0]         r_cnt;
  logic               r_err;

  logic               aw_oor_c;
  logic               ar_oor_c;
  logic               w_hs_c;
  logic               w_cnt_end_c;
  logic [STRB_W-1:0]  wr_be_c;
  logic               rd_en_c;

  // Any address bit above the word-index field marks the burst out of range.
  assign aw_oor_c    = |(s_axi.s_axi_awaddr >> HI_LSB);
  assign ar_oor_c    = |(s_axi.s_axi_araddr >> HI_LSB);
  assign w_hs_c      = (wstate == W_DATA) && s_axi.s_axi_wvalid && s_axi.s_axi_wready;
  assign w_cnt_end_c = (w_cnt == w_len);
  assign wr_be_c     = (w_hs_c && !w_err) ? s_axi.s_axi_wstrb : '0;
  assign rd_en_c     = (rstate == R_FETCH);

  // Write channel FSM: AW latch, data beats, single B response.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      wstate              <= W_IDLE;
      w_idx               <= '0;
      w_id                <= '0;
      w_len               <= '0;
      w_cnt               <= '0;
      w_err               <= 1'b0;
      s_axi.s_axi_awready <= 1'b0;
      s_axi.s_axi_wready  <= 1'b0;
      s_axi.s_axi_bvalid  <= 1'b0;
      s_axi.s_axi_bresp   <= RESP_OKAY;
      s_axi.s_axi_bid     <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          s_axi.s_axi_awready <= 1'b1;
          if (s_axi.s_axi_awvalid && s_axi.s_axi_awready) begin
            w_idx               <= s_axi.s_axi_awaddr[OFF_W +: IDX_W];
            w_id                <= s_axi.s_axi_awid;
            w_len               <= s_axi.s_axi_awlen;
            w_cnt               <= '0;
            w_err               <= aw_oor_c;
            s_axi.s_axi_awready <= 1'b0;
            s_axi.s_axi_wready  <= 1'b1;
            wstate              <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs_c) begin
            if (s_axi.s_axi_wlast || w_cnt_end_c) begin
              s_axi.s_axi_wready <= 1'b0;
              s_axi.s_axi_bvalid <= 1'b1;
              s_axi.s_axi_bid    <= w_id;
              s_axi.s_axi_bresp  <= (w_err || (s_axi.s_axi_wlast != w_cnt_end_c))
                                    ? RESP_SLVERR : RESP_OKAY;
              wstate             <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              w_idx <= w_idx + IDX_W'(1);
            end
          end
        end
        W_RESP: begin
          if (s_axi.s_axi_bvalid && s_axi.s_axi_bready) begin
            s_axi.s_axi_bvalid  <= 1'b0;
            s_axi.s_axi_awready <= 1'b1;
            wstate              <= W_IDLE;
          end
        end
        default: begin
          wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM: AR latch, then alternate memory fetch and R beat.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      rstate              <= R_IDLE;
      r_idx               <= '0;
      r_id                <= '0;
      r_len               <= '0;
      r_cnt               <= '0;
      r_err               <= 1'b0;
      s_axi.s_axi_arready <= 1'b0;
      s_axi.s_axi_rvalid  <= 1'b0;
      s_axi.s_axi_rlast   <= 1'b0;
      s_axi.s_axi_rresp   <= RESP_OKAY;
      s_axi.s_axi_rid     <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          s_axi.s_axi_arready <= 1'b1;
          if (s_axi.s_axi_arvalid && s_axi.s_axi_arready) begin
            r_idx               <= s_axi.s_axi_araddr[OFF_W +: IDX_W];
            r_id                <= s_axi.s_axi_arid;
            r_len               <= s_axi.s_axi_arlen;
            r_cnt               <= '0;
            r_err               <= ar_oor_c;
            s_axi.s_axi_arready <= 1'b0;
            rstate              <= R_FETCH;
          end
        end
        R_FETCH: begin
          s_axi.s_axi_rvalid <= 1'b1;
          s_axi.s_axi_rlast  <= (r_cnt == r_len);
          s_axi.s_axi_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
          s_axi.s_axi_rid    <= r_id;
          rstate             <= R_DATA;
        end
        R_DATA: begin
          if (s_axi.s_axi_rvalid && s_axi.s_axi_rready) begin
            s_axi.s_axi_rvalid <= 1'b0;
            s_axi.s_axi_rlast  <= 1'b0;
            if (r_cnt == r_len) begin
              s_axi.s_axi_arready <= 1'b1;
              rstate              <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_idx  <= r_idx + IDX_W'(1);
              rstate <= R_FETCH;
            end
          end
        end
        default: begin
          rstate <= R_IDLE;
        end
      endcase
    end
  end

  // Backing store; its registered read port drives rdata directly.
  axi_responder_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (s_axi_aclk),
    .rst     (s_axi_areset),
    .wr_idx  (w_idx),
    .wr_be   (wr_be_c),
    .wr_data (s_axi.s_axi_wdata),
    .rd_en   (rd_en_c),
    .rd_clr  (r_err),
    .rd_idx  (r_idx),
    .rd_data (s_axi.s_axi_rdata)
  );

endmodule : axi_responder

// File: tb/tb_axi_responder.sv
// Directed self-checking bench for axi_responder.
module tb_axi_responder;
  import axi_responder_pkg::*;

  logic clk;
  logic areset;
  int   checks;
  int   failures;

  axi_responder_if #(.ADDR_W(40), .ID_W(16), .DATA_W(128)) bus ();

  axi_responder #(
    .ADDR_W (40),
    .ID_W   (16),
    .DATA_W (128),
    .DEPTH  (256)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (areset),
    .s_axi        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic aw_send(input logic [39:0] addr, input logic [7:0] len, input logic [15:0] id);
    int n;
    @(negedge clk);
    bus.s_axi_awaddr = addr; bus.s_axi_awlen = len; bus.s_axi_awid = id; bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_handshake", 128'(bus.s_axi_awready), 128'd1);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [127:0] data, input logic [15:0] strb, input logic last);
    int n;
    bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wlast = last; bus.s_axi_wvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_wready && n < 50) begin @(negedge clk); n++; end
    chk("w_handshake", 128'(bus.s_axi_wready), 128'd1);
    @(negedge clk);
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
  endtask

  task automatic b_wait(input string tag, input logic [1:0] resp, input logic [15:0] id);
    int n;
    bus.s_axi_bready = 1'b1;
    n = 0;
    while (!bus.s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_bvalid"}, 128'(bus.s_axi_bvalid), 128'd1);
    chk({tag, "_bresp"}, 128'(bus.s_axi_bresp), 128'(resp));
    chk({tag, "_bid"}, 128'(bus.s_axi_bid), 128'(id));
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    chk({tag, "_bvalid_clr"}, 128'(bus.s_axi_bvalid), 128'd0);
  endtask

  task automatic ar_send(input logic [39:0] addr, input logic [7:0] len, input logic [15:0] id);
    int n;
    @(negedge clk);
    bus.s_axi_araddr = addr; bus.s_axi_arlen = len; bus.s_axi_arid = id; bus.s_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_handshake", 128'(bus.s_axi_arready), 128'd1);
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [127:0] data, input logic [1:0] resp,
                        input logic [15:0] id, input logic last, input int stall);
    int n;
    bus.s_axi_rready = (stall == 0);
    n = 0;
    while (!bus.s_axi_rvalid && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_rvalid"}, 128'(bus.s_axi_rvalid), 128'd1);
    chk({tag, "_rdata"}, bus.s_axi_rdata, data);
    chk({tag, "_rresp"}, 128'(bus.s_axi_rresp), 128'(resp));
    chk({tag, "_rid"}, 128'(bus.s_axi_rid), 128'(id));
    chk({tag, "_rlast"}, 128'(bus.s_axi_rlast), 128'(last));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({tag, "_stall_rvalid"}, 128'(bus.s_axi_rvalid), 128'd1);
      chk({tag, "_stall_rdata"}, bus.s_axi_rdata, data);
      chk({tag, "_stall_rlast"}, 128'(bus.s_axi_rlast), 128'(last));
    end
    bus.s_axi_rready = 1'b1;
    @(negedge clk);
    bus.s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [127:0] ones;
    logic [127:0] cc;
    ones = '1;
    cc   = {16{8'hCC}};
    checks = 0; failures = 0;
    bus.s_axi_awaddr = '0; bus.s_axi_awid = '0; bus.s_axi_awlen = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arid = '0; bus.s_axi_arlen = '0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
    areset = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_awready", 128'(bus.s_axi_awready), 128'd0);
    chk("rst_arready", 128'(bus.s_axi_arready), 128'd0);
    chk("rst_wready", 128'(bus.s_axi_wready), 128'd0);
    chk("rst_bvalid", 128'(bus.s_axi_bvalid), 128'd0);
    chk("rst_rvalid", 128'(bus.s_axi_rvalid), 128'd0);
    chk("rst_rlast", 128'(bus.s_axi_rlast), 128'd0);
    chk("rst_rdata", bus.s_axi_rdata, 128'd0);
    chk("rst_bid", 128'(bus.s_axi_bid), 128'd0);
    chk("rst_rid", 128'(bus.s_axi_rid), 128'd0);
    areset = 1'b0;
    @(negedge clk);
    chk("rel_awready", 128'(bus.s_axi_awready), 128'd1);
    chk("rel_arready", 128'(bus.s_axi_arready), 128'd1);

    // Basic 4-beat write and read back
    aw_send(40'h100, 8'd3, 16'h5);
    chk("aw_busy_awready", 128'(bus.s_axi_awready), 128'd0);
    for (int i = 0; i < 4; i++) w_beat(128'hA0 + 128'(i), 16'hFFFF, i == 3);
    b_wait("basic", RESP_OKAY, 16'h5);
    ar_send(40'h100, 8'd3, 16'h9);
    chk("basic_fetch_rvalid", 128'(bus.s_axi_rvalid), 128'd0);
    chk("ar_busy_arready", 128'(bus.s_axi_arready), 128'd0);
    for (int i = 0; i < 4; i++) r_beat("basic", 128'hA0 + 128'(i), RESP_OKAY, 16'h9, i == 3, 0);

    // Index wrap 255 -> 0 within a burst
    aw_send(40'hFF0, 8'd1, 16'h1);
    w_beat(ones, 16'hFFFF, 1'b0);
    w_beat(128'h1234, 16'hFFFF, 1'b1);
    b_wait("wrap", RESP_OKAY, 16'h1);
    ar_send(40'hFF0, 8'd0, 16'h2);
    r_beat("wrap255", ones, RESP_OKAY, 16'h2, 1'b1, 0);
    ar_send(40'h000, 8'd0, 16'h3);
    r_beat("wrap0", 128'h1234, RESP_OKAY, 16'h3, 1'b1, 0);

    // Byte strobes
    aw_send(40'h300, 8'd0, 16'h6);
    w_beat(cc, 16'hFFFF, 1'b1);
    b_wait("strb_a", RESP_OKAY, 16'h6);
    aw_send(40'h300, 8'd0, 16'h6);
    w_beat({16{8'h55}}, 16'h0001, 1'b1);
    b_wait("strb_b", RESP_OKAY, 16'h6);
    ar_send(40'h300, 8'd0, 16'h6);
    r_beat("strb", {cc[127:8], 8'h55}, RESP_OKAY, 16'h6, 1'b1, 0);

    // Out-of-range write aliases index 0x10 but must not land
    aw_send(40'h80_0000_0100, 8'd0, 16'h7);
    w_beat(128'hDEAD, 16'hFFFF, 1'b1);
    b_wait("oor_w", RESP_SLVERR, 16'h7);
    ar_send(40'h100, 8'd0, 16'h7);
    r_beat("oor_w_chk", 128'hA0, RESP_OKAY, 16'h7, 1'b1, 0);

    // Out-of-range read returns zeros with SLVERR
    ar_send(40'h10_0100, 8'd1, 16'h8);
    r_beat("oor_r0", 128'd0, RESP_SLVERR, 16'h8, 1'b0, 0);
    r_beat("oor_r1", 128'd0, RESP_SLVERR, 16'h8, 1'b1, 0);

    // Early wlast on beat 1 of a len=3 burst
    aw_send(40'h200, 8'd3, 16'h3);
    w_beat(128'h11, 16'hFFFF, 1'b0);
    w_beat(128'h22, 16'hFFFF, 1'b1);
    chk("early_wready", 128'(bus.s_axi_wready), 128'd0);
    b_wait("early", RESP_SLVERR, 16'h3);
    ar_send(40'h200, 8'd1, 16'h3);
    r_beat("early_r0", 128'h11, RESP_OKAY, 16'h3, 1'b0, 0);
    r_beat("early_r1", 128'h22, RESP_OKAY, 16'h3, 1'b1, 0);

    // R backpressure mid-burst
    ar_send(40'h100, 8'd3, 16'h2);
    r_beat("stall0", 128'hA0, RESP_OKAY, 16'h2, 1'b0, 0);
    r_beat("stall1", 128'hA1, RESP_OKAY, 16'h2, 1'b0, 5);
    r_beat("stall2", 128'hA2, RESP_OKAY, 16'h2, 1'b0, 0);
    r_beat("stall3", 128'hA3, RESP_OKAY, 16'h2, 1'b1, 0);

    // Reset in the middle of a read burst
    ar_send(40'h100, 8'd3, 16'h4);
    r_beat("mid0", 128'hA0, RESP_OKAY, 16'h4, 1'b0, 0);
    areset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rvalid", 128'(bus.s_axi_rvalid), 128'd0);
    chk("mid_rst_arready", 128'(bus.s_axi_arready), 128'd0);
    areset = 1'b0;
    @(negedge clk);
    chk("mid_rel_arready", 128'(bus.s_axi_arready), 128'd1);
    chk("mid_rel_rvalid", 128'(bus.s_axi_rvalid), 128'd0);
    ar_send(40'h100, 8'd1, 16'h4);
    r_beat("post_rst0", 128'hA0, RESP_OKAY, 16'h4, 1'b0, 0);
    r_beat("post_rst1", 128'hA1, RESP_OKAY, 16'h4, 1'b1, 0);
    ar_send(40'h200, 8'd0, 16'h4);
    r_beat("post_rst2", 128'h11, RESP_OKAY, 16'h4, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_axi_responder
